// File: rtl/seq_signed_divider.sv
// ============================================================================
//  Module      : seq_signed_divider
//  Description : Sequential restoring signed divider, one quotient bit per
//                clock, truncating toward zero, with divide-by-zero and
//                overflow flags and a start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_signed_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz,
    output logic          ovf
);

    localparam int c_CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2
    } state_t;

    state_t          r_state;
    logic [c_CW-1:0] r_count;
    logic [VW-1:0]   r_rem;
    logic [DW-1:0]   r_dmag;
    logic [VW-1:0]   r_vmag;
    logic            r_sn_dd;
    logic            r_sn_vs;
    logic            r_dbz;
    logic            r_ovf;

    // Running remainder never exceeds |divisor|-1 < 2^(VW-1), so after the
    // shift it fits VW bits; the extra top bit carries the trial sign.
    logic [VW:0]     w_shift;
    logic [VW:0]     w_diff;
    logic            w_qbit;

    assign w_shift = {r_rem, r_dmag[DW-1]};
    assign w_diff  = w_shift - {1'b0, r_vmag};
    assign w_qbit  = ~w_diff[VW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_rem     <= '0;
            r_dmag    <= '0;
            r_vmag    <= '0;
            r_sn_dd   <= 1'b0;
            r_sn_vs   <= 1'b0;
            r_dbz     <= 1'b0;
            r_ovf     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_sn_dd <= dividend[DW-1];
                        r_sn_vs <= divisor[VW-1];
                        r_dmag  <= dividend[DW-1] ? -dividend : dividend;
                        r_vmag  <= divisor[VW-1]  ? -divisor  : divisor;
                        r_dbz   <= (divisor == '0);
                        r_ovf   <= (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == '1);
                        r_rem   <= '0;
                        r_count <= c_CW'(DW);
                        busy    <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_rem   <= w_qbit ? w_diff[VW-1:0] : w_shift[VW-1:0];
                    r_dmag  <= {r_dmag[DW-2:0], w_qbit};
                    r_count <= r_count - 1'b1;
                    if (r_count == c_CW'(1)) begin
                        r_state <= S_SIGN;
                    end
                end
                S_SIGN: begin
                    // Divide-by-zero leaves garbage in the datapath; force the defined result.
                    if (r_dbz) begin
                        quotient  <= '1;
                        remainder <= '0;
                    end else begin
                        quotient  <= (r_sn_dd ^ r_sn_vs) ? -r_dmag : r_dmag;
                        remainder <= r_sn_dd ? -r_rem : r_rem;
                    end
                    dbz     <= r_dbz;
                    ovf     <= r_ovf & ~r_dbz;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_signed_divider.sv
// ============================================================================
//  Module      : tb_seq_signed_divider
//  Description : Self-checking bench for seq_signed_divider against an
//                integer-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_signed_divider;

    localparam int c_DW  = 8;
    localparam int c_VW  = 4;
    localparam int c_LAT = c_DW + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [c_DW-1:0] dividend = '0;
    logic [c_VW-1:0] divisor = '0;
    logic            busy;
    logic            done;
    logic [c_DW-1:0] quotient;
    logic [c_VW-1:0] remainder;
    logic            dbz;
    logic            ovf;

    int n_chk  = 0;
    int n_pass = 0;

    seq_signed_divider #(.DW(c_DW), .VW(c_VW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: plain signed integer division, truncating toward zero.
    task automatic model(input int d, input int v, output int q, output int r,
                         output bit e_dbz, output bit e_ovf);
        e_dbz = 1'b0;
        e_ovf = 1'b0;
        if (v == 0) begin
            q = -1; r = 0; e_dbz = 1'b1;
        end else if (d == -(1 << (c_DW - 1)) && v == -1) begin
            q = d; r = 0; e_ovf = 1'b1;
        end else begin
            q = d / v; r = d % v;
        end
    endtask

    // Waits for done after the accepting edge; returns edges counted and busy consistency.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 40) begin
            if (lat > 0 && !busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (busy) busy_ok = 1'b0;
    endtask

    task automatic check_result(input string tag, input int d, input int v, input int lat,
                                input bit busy_ok);
        int q, r;
        bit e_dbz, e_ovf;
        logic [c_DW-1:0] eq;
        logic [c_VW-1:0] er;
        model(d, v, q, r, e_dbz, e_ovf);
        eq = q[c_DW-1:0];
        er = r[c_VW-1:0];
        chk($sformatf("%s lat %0d/%0d", tag, d, v), lat, c_LAT);
        chk($sformatf("%s busy %0d/%0d", tag, d, v), {31'b0, busy_ok}, 32'd1);
        chk($sformatf("%s quo %0d/%0d", tag, d, v), {24'b0, quotient}, {24'b0, eq});
        chk($sformatf("%s rem %0d/%0d", tag, d, v), {28'b0, remainder}, {28'b0, er});
        chk($sformatf("%s dbz %0d/%0d", tag, d, v), {31'b0, dbz}, {31'b0, e_dbz});
        chk($sformatf("%s ovf %0d/%0d", tag, d, v), {31'b0, ovf}, {31'b0, e_ovf});
    endtask

    task automatic do_op(input string tag, input int d, input int v);
        int lat;
        bit bok;
        @(negedge clk);
        start = 1'b1;
        dividend = d[c_DW-1:0];
        divisor = v[c_VW-1:0];
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bok);
        check_result(tag, d, v, lat, bok);
    endtask

    initial begin
        int lat, dones;
        bit bok;

        #12;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset quo", {24'b0, quotient}, 32'd0);
        chk("reset rem", {28'b0, remainder}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("dir", 100, 7);
        @(posedge clk); #1;
        chk("done one pulse", {31'b0, done}, 32'd0);
        chk("hold quo", {24'b0, quotient}, 32'd14);
        do_op("dir", -100, 7);
        do_op("dir", 100, -7);
        do_op("dir", -100, -7);
        do_op("dir", 7, -8);
        do_op("dir", -128, -8);
        do_op("dir", 5, 0);
        do_op("dir", -128, -1);
        do_op("dir", -128, 1);

        // Start held high while busy must not disturb the in-flight 50/3.
        @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 4'd3;
        @(posedge clk); #1;
        dividend = 8'd9; divisor = 4'd2;
        wait_done(lat, bok);
        check_result("hs1", 50, 3, lat, bok);
        @(posedge clk); #1;
        start = 1'b0;
        chk("hs accept busy", {31'b0, busy}, 32'd1);
        wait_done(lat, bok);
        check_result("hs2", 9, 2, lat, bok);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst busy", {31'b0, busy}, 32'd0);
        chk("arst done", {31'b0, done}, 32'd0);
        chk("arst quo", {24'b0, quotient}, 32'd0);
        chk("arst rem", {28'b0, remainder}, 32'd0);
        chk("arst flags", {30'b0, dbz, ovf}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (14) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("arst no done", dones, 0);
        do_op("post-rst", 20, 6);

        repeat (400) begin
            int d, v;
            d = int'($urandom_range(255)) - 128;
            v = int'($urandom_range(15)) - 8;
            do_op("rnd", d, v);
        end

        for (int d = -128; d < 128; d++) begin
            for (int v = -8; v < 8; v++) begin
                do_op("sweep", d, v);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
